mem_arbiter_rr: RTL and testbench

- N-client memory-port arbiter; parametrised successor to the two-client I/D miss-fetch controller.
- Sits between the cache miss handlers and the single multi-cycle memory.
- Grants one requesting cache at a time, counts refill beats returned by memory, and signals line completion to the owner.
- Round-robin (fair) or fixed-priority mode selectable by parameter.

---
 rtl/mem_arbiter_rr.sv | 108 ++++++++++
 tb/tb_mem_arbiter_rr.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// N-client memory-port arbiter: grants one cache miss at a time, counts refill
// beats and pulses done to the owner after the final beat.
module mem_arbiter_rr #(
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned BEATS       = 8,
    parameter int unsigned FIXED_PRIO  = 0,
    localparam int unsigned ID_W       = $clog2(NUM_CLIENTS),
    localparam int unsigned BEAT_W     = $clog2(BEATS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic                   mem_data_valid,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic [ID_W-1:0]        grant_id,
    output logic                   mem_fetch,
    output logic [BEAT_W-1:0]      beat_idx,
    output logic [NUM_CLIENTS-1:0] done,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [ID_W-1:0]   LAST_CLIENT = ID_W'(NUM_CLIENTS - 1);

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win_id;
    logic            win_found;
    logic [ID_W-1:0] next_ptr;
    int unsigned     idx;

    // Winner: first request scanning upward from ptr (round-robin) or from 0 (fixed).
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (FIXED_PRIO != 0) begin
                idx = i;
            end else begin
                idx = (32'(ptr) + i) % NUM_CLIENTS;
            end
            if (!win_found && req[ID_W'(idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign next_ptr = (grant_id == LAST_CLIENT) ? '0 : grant_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_id  <= '0;
            mem_fetch <= 1'b0;
            beat_idx  <= '0;
            done      <= '0;
            busy      <= 1'b0;
            ptr       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= FETCH;
                        grant     <= NUM_CLIENTS'(1) << win_id;
                        grant_id  <= win_id;
                        mem_fetch <= 1'b1;
                        beat_idx  <= '0;
                        busy      <= 1'b1;
                    end
                end
                FETCH: begin
                    // Owner and grant are frozen; only memory beats advance the refill.
                    if (mem_data_valid) begin
                        if (beat_idx == LAST_BEAT) begin
                            state     <= DONE;
                            done      <= grant;
                            grant     <= '0;
                            grant_id  <= '0;
                            mem_fetch <= 1'b0;
                            beat_idx  <= '0;
                            ptr       <= next_ptr;
                        end else begin
                            beat_idx <= beat_idx + BEAT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: 2-client RR, 4-client RR and 4-client
// fixed-priority instances share clock and reset.
module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cd4 [4] = '{0, 0, 0, 0};

    logic [1:0] req2 = '0;
    logic       v2 = 1'b0;
    logic [1:0] g2, d2;
    logic [0:0] id2;
    logic [2:0] b2;
    logic       f2, y2;

    logic [3:0] req4 = '0;
    logic       v4 = 1'b0;
    logic [3:0] g4, d4;
    logic [1:0] id4;
    logic [2:0] b4;
    logic       f4, y4;

    logic [3:0] reqf = '0;
    logic       vf = 1'b0;
    logic [3:0] gf, df;
    logic [1:0] idf;
    logic [2:0] bf;
    logic       ff, yf;

    mem_arbiter_rr #(.NUM_CLIENTS(2), .BEATS(8), .FIXED_PRIO(0)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .mem_data_valid(v2), .grant(g2),
        .grant_id(id2), .mem_fetch(f2), .beat_idx(b2), .done(d2), .busy(y2));

    mem_arbiter_rr #(.NUM_CLIENTS(4), .BEATS(8), .FIXED_PRIO(0)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .mem_data_valid(v4), .grant(g4),
        .grant_id(id4), .mem_fetch(f4), .beat_idx(b4), .done(d4), .busy(y4));

    mem_arbiter_rr #(.NUM_CLIENTS(4), .BEATS(8), .FIXED_PRIO(1)) dutf (
        .clk(clk), .rst(rst), .req(reqf), .mem_data_valid(vf), .grant(gf),
        .grant_id(idf), .mem_fetch(ff), .beat_idx(bf), .done(df), .busy(yf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; re-raise dropped 4-client requests when their delay expires.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (cd4[i] > 0) begin
                cd4[i]--;
                if (cd4[i] == 0) req4[i] = 1'b1;
            end
        end
    endtask

    initial begin
        int n;
        int cnt;
        int cyc;
        int exp_beat;
        int bad3;
        int ndone;

        // Reset held: requests and valids toggling must not disturb anything.
        req2 = 2'b11; req4 = 4'hF; reqf = 4'hF;
        for (int i = 0; i < 4; i++) begin
            v2 = ~v2; v4 = ~v4; vf = ~vf;
            step();
            chk("rst_grant2", 32'(g2), 32'h0);
            chk("rst_id2", 32'(id2), 32'h0);
            chk("rst_fetch2", 32'(f2), 32'h0);
            chk("rst_beat2", 32'(b2), 32'h0);
            chk("rst_done2", 32'(d2), 32'h0);
            chk("rst_busy2", 32'(y2), 32'h0);
        end
        chk("rst_grant4", 32'(g4), 32'h0);
        chk("rst_busy4", 32'(y4), 32'h0);
        chk("rst_grantf", 32'({gf, idf, bf, ff, df, yf}), 32'h0);

        req2 = '0; req4 = '0; reqf = '0; v2 = 1'b0; v4 = 1'b0; vf = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_busy2", 32'(y2), 32'h0);
            chk("idle_busy4", 32'(y4), 32'h0);
        end

        // Single refill, client 0, valid every cycle.
        req2 = 2'b01; v2 = 1'b1;
        step();
        chk("sr_grant", 32'(g2), 32'h1);
        chk("sr_id", 32'(id2), 32'h0);
        chk("sr_fetch", 32'(f2), 32'h1);
        chk("sr_busy", 32'(y2), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("sr_beat", 32'(b2), 32'(i));
            chk("sr_grant_hold", 32'(g2), 32'h1);
            chk("sr_no_done", 32'(d2), 32'h0);
            step();
        end
        chk("sr_done", 32'(d2), 32'h1);
        chk("sr_done_grant", 32'(g2), 32'h0);
        chk("sr_done_fetch", 32'(f2), 32'h0);
        chk("sr_done_beat", 32'(b2), 32'h0);
        chk("sr_done_busy", 32'(y2), 32'h1);
        req2 = 2'b00;
        step();
        chk("sr_pulse_once", 32'(d2), 32'h0);
        chk("sr_busy_clear", 32'(y2), 32'h0);
        step();
        chk("sr_valid_idle_beat", 32'(b2), 32'h0);
        chk("sr_valid_idle_busy", 32'(y2), 32'h0);

        // Stalled memory: valid on 3 of every 5 cycles, client 1.
        req2 = 2'b10; v2 = 1'b0;
        step();
        chk("st_grant", 32'(g2), 32'h2);
        chk("st_id", 32'(id2), 32'h1);
        cnt = 0; cyc = 0; exp_beat = 0;
        while (cnt < 8 && cyc < 100) begin
            v2 = ((cyc % 5) < 3);
            chk("st_beat", 32'(b2), 32'(exp_beat));
            chk("st_grant_hold", 32'(g2), 32'h2);
            chk("st_no_done", 32'(d2), 32'h0);
            step();
            if (v2) begin
                cnt++;
                exp_beat = (exp_beat + 1) % 8;
            end
            cyc++;
        end
        chk("st_done", 32'(d2), 32'h2);
        chk("st_done_grant", 32'(g2), 32'h0);
        req2 = 2'b00; v2 = 1'b0;
        step();

        // Round-robin: all four request; each drops after done, re-raises 2 cycles later.
        req4 = 4'hF; v4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (g4 == 4'h0 && n < 50) begin step(); n++; end
            chk("rr_grant", 32'(g4), 32'(1) << (k % 4));
            chk("rr_id", 32'(id4), 32'(k % 4));
            n = 0;
            while (d4 == 4'h0 && n < 50) begin step(); n++; end
            chk("rr_done", 32'(d4), 32'(1) << (k % 4));
            req4[k % 4] = 1'b0;
            cd4[k % 4] = 2;
            step();
            chk("rr_idle_gap", 32'(g4), 32'h0);
        end
        req4 = 4'h0; v4 = 1'b0;
        for (int i = 0; i < 4; i++) cd4[i] = 0;
        step();

        // Fixed priority: client 1 keeps winning over client 3.
        reqf = 4'b1010; vf = 1'b1;
        bad3 = 0; ndone = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (gf[3]) bad3++;
            if (gf != 4'h0) chk("fp_grant", 32'({gf, idf}), 32'({4'b0010, 2'd1}));
            if (df != 4'h0) begin
                ndone++;
                chk("fp_done", 32'(df), 32'h2);
            end
        end
        chk("fp_ndone", 32'(ndone), 32'd4);
        chk("fp_never3", 32'(bad3), 32'd0);
        reqf = 4'h0; vf = 1'b0;
        step(); step();

        // Reset in the middle of a refill aborts it without a done pulse.
        req4 = 4'b0001; v4 = 1'b1;
        step();
        chk("rm_grant", 32'(g4), 32'h1);
        for (int i = 0; i < 4; i++) step();
        chk("rm_beat4", 32'(b4), 32'h4);
        rst = 1'b0;
        #1;
        chk("rm_grant_clr", 32'(g4), 32'h0);
        chk("rm_fetch_clr", 32'(f4), 32'h0);
        chk("rm_beat_clr", 32'(b4), 32'h0);
        chk("rm_no_done", 32'(d4), 32'h0);
        chk("rm_busy_clr", 32'(y4), 32'h0);
        req4 = 4'b0100;
        step();
        chk("rm_hold_done", 32'(d4), 32'h0);
        rst = 1'b1;
        step();
        chk("rm_regrant", 32'(g4), 32'h4);
        chk("rm_regrant_id", 32'(id4), 32'h2);
        chk("rm_restart_beat", 32'(b4), 32'h0);
        for (int i = 0; i < 8; i++) step();
        chk("rm_done", 32'(d4), 32'h4);
        req4 = 4'h0; v4 = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
